jk_bank_arbiter: RTL and testbench
==================================

# jk_bank_arbiter

Round-robin arbiter and sequencer that shares one bank of WIDTH JK flip-flops among NREQ requesters. Each requester posts a per-bit command (hold/set/reset/toggle) with a bit mask. The block grants one requester at a time, drives the J/K inputs of the masked bits for exactly one enabled clock, and acknowledges completion. It sits between the control agents and the JK storage bank and is the only writer of that bank.

## Interface
- WIDTH, 8, number of JK bits in the bank (1..32)
- NREQ, 4, number of requesters (2..8)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  NREQ  request per requester; held high until its gnt pulse
- op  input  2*NREQ  command for requester i at op[2i+1:2i]: 00 hold, 01 reset, 10 set, 11 toggle
- mask  input  WIDTH*NREQ  bit select for requester i at mask[WIDTH*i +: WIDTH]; 1 = bit affected
- gnt  output  NREQ  one-hot, one-cycle completion pulse to the served requester
- gnt_id  output  $clog2(NREQ)  index of the last served requester, stable until next grant
- busy  output  1  high while a command is latched or executing
- q  output  WIDTH  JK bank state

## Operation
- FSM states: IDLE, APPLY, ACK.
- IDLE: if any req is high, select the first requester at or after the round-robin pointer `ptr`, wrapping modulo NREQ. Latch its op, its mask and its index. Go to APPLY. If no req is high, stay in IDLE.
- APPLY: assert the bank enable for one cycle. For each masked bit, J/K = op decode: reset J=0 K=1, set J=1 K=0, toggle J=1 K=1, hold J=0 K=0. Unmasked bits get J=K=0. At the end of the cycle, q takes the JK result: toggle gives ~q. Go to ACK.
- ACK: pulse gnt[idx] and update gnt_id to idx. Set ptr to (idx+1) mod NREQ. Return to IDLE.
- Arbitration uses only the latched copy. Changes to req, op or mask after latching do not affect the command in flight.
- A req that drops before it is sampled in IDLE is never served and produces no gnt.
- op=00, or mask of all zeros, still runs the full IDLE→APPLY→ACK sequence and produces gnt. q is unchanged.
- A requester that keeps req high after its gnt is re-arbitrated in the next IDLE cycle with lowest priority. No back-to-back starvation.
- busy = (state != IDLE).

## Timing
- Reset values: q=0, gnt=0, gnt_id=0, busy=0, ptr=0, state=IDLE.
- req sampled high at edge t (IDLE) → APPLY during t..t+1 → q updated at edge t+2 → gnt high for the cycle after edge t+2. q already reflects the command while gnt is high.
- Service cadence: one command per 3 cycles under continuous requests.
- Fairness: with all NREQ requesting continuously, each requester is served exactly once per 3*NREQ cycles.
- rst high at any edge, including in APPLY or ACK, wins: the in-flight command is discarded, no gnt is issued, and all reset values apply on the next cycle.
- The q update is purely edge-triggered from the bank. There is no level-sensitive transparency.

## Structure
- Shared package jk_pkg holds: op encoding constants (OP_HOLD=2'b00, OP_RST=2'b01, OP_SET=2'b10, OP_TGL=2'b11), the FSM state enum, and a function that decodes op+mask into J/K vectors.
- Sub-module jk_ff_bank(clk, rst, en, j[WIDTH], k[WIDTH], q[WIDTH]) is a clocked JK register bank with synchronous active-high reset to 0.
- The top level contains the round-robin selector, the latch registers and the FSM.

## Test plan
- Reset then single request: req=0001, op0=10, mask0=8'hF0 → gnt=0001 three cycles after req; q=8'hF0; gnt_id=0.
- Toggle twice: after q=8'hF0, req1 op=11 mask=8'hFF → q=8'h0F; repeat → q=8'hF0; each gnt=0010 for exactly one cycle.
- Round-robin fairness: all four req held high with op=hold → gnt order 0,1,2,3,0 at 3-cycle spacing; q unchanged.
- Pointer wrap: ptr at 3 (after serving 2) with req=1001 → requester 3 served first, then 0.
- Mid-flight change: req2 latched with op=set mask=8'h01; op2/mask2 changed to reset/8'hFF during APPLY → q bit0=1, other bits unchanged.
- Reset mid-op: rst asserted during APPLY → no gnt, q=0, busy=0 next cycle; the next request is served starting from requester 0.

Source files
------------

// File: rtl/jk_bank_arbiter_pkg.sv
// Shared definitions for the JK bank arbiter: op encodings, FSM states
// and the per-bit J/K decode used when a latched command is applied.
package jk_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_RST  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_TGL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_APPLY = 2'b01,
    ST_ACK   = 2'b10
  } state_e;

  // Decode one command and one mask bit into {J, K}.
  // A cleared mask bit always yields J=K=0 so the bit holds.
  function automatic logic [1:0] jk_decode(input logic [1:0] op, input logic mask_bit);
    logic [1:0] jk;
    case (op)
      OP_HOLD: jk = 2'b00;
      OP_RST:  jk = 2'b01;
      OP_SET:  jk = 2'b10;
      OP_TGL:  jk = 2'b11;
      default: jk = 2'b00;
    endcase
    if (mask_bit) begin
      return jk;
    end else begin
      return 2'b00;
    end
  endfunction

endpackage

// File: rtl/jk_bank_arbiter_if.sv
// Requester-side bus of the JK bank arbiter. The master modport is the
// side of the control agents, the slave modport is the arbiter itself.
interface jk_bank_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req;
  logic [2*NREQ-1:0]     op;
  logic [WIDTH*NREQ-1:0] mask;
  logic [NREQ-1:0]       gnt;
  logic [IDW-1:0]        gnt_id;
  logic                  busy;
  logic [WIDTH-1:0]      q;

  modport master (
    output req, op, mask,
    input  gnt, gnt_id, busy, q
  );

  modport slave (
    input  req, op, mask,
    output gnt, gnt_id, busy, q
  );
endinterface

// File: rtl/jk_bank_arbiter_ff_bank.sv
// Bank of WIDTH JK flip-flops, written only when en is high.
module jk_ff_bank #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // JK next-state: set where J only, clear where K only, flip where both.
  always_comb begin
    q_d = (j & ~q_q) | (~k & q_q);
  end

  // Bank storage; reset wins over a pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= {WIDTH{1'b0}};
    end else if (en) begin
      q_q <= q_d;
    end else begin
      q_q <= q_q;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter/sequencer that serves one requester at a time
// against a shared JK flip-flop bank: IDLE picks and latches a command,
// APPLY loads the bank J/K/enable registers, ACK pulses the grant.
module jk_bank_arbiter
  import jk_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input logic               clk,
  input logic               rst,
  jk_bank_arbiter_if.slave  bus
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e           state_q;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   idx_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] mask_q;
  logic             en_q;
  logic [WIDTH-1:0] j_q;
  logic [WIDTH-1:0] k_q;
  logic [NREQ-1:0]  gnt_q;
  logic [IDW-1:0]   gnt_id_q;
  logic             busy_q;

  logic             sel_found_d;
  logic [IDW-1:0]   sel_idx_d;
  logic [IDW:0]     sel_sum_d;
  logic [IDW-1:0]   sel_cand_d;
  logic [1:0]       sel_op_d;
  logic [WIDTH-1:0] sel_mask_d;
  logic [WIDTH-1:0] j_d;
  logic [WIDTH-1:0] k_d;
  logic [IDW-1:0]   ptr_next_d;
  logic [WIDTH-1:0] bank_q;

  // Round-robin pick: scan offsets from highest to lowest so the requester
  // closest at-or-after ptr is the last one written and therefore wins.
  always_comb begin
    sel_found_d = 1'b0;
    sel_idx_d   = {IDW{1'b0}};
    sel_sum_d   = {(IDW+1){1'b0}};
    sel_cand_d  = {IDW{1'b0}};
    for (int off = NREQ - 1; off >= 0; off--) begin
      sel_sum_d = {1'b0, ptr_q} + (IDW+1)'(off);
      if (sel_sum_d >= (IDW+1)'(NREQ)) begin
        sel_cand_d = IDW'(sel_sum_d - (IDW+1)'(NREQ));
      end else begin
        sel_cand_d = sel_sum_d[IDW-1:0];
      end
      if (bus.req[sel_cand_d]) begin
        sel_found_d = 1'b1;
        sel_idx_d   = sel_cand_d;
      end else begin
        sel_found_d = sel_found_d;
        sel_idx_d   = sel_idx_d;
      end
    end
  end

  // Extract the chosen requester's op and mask fields from the flat buses.
  always_comb begin
    sel_op_d   = OP_HOLD;
    sel_mask_d = {WIDTH{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      if (sel_idx_d == IDW'(i)) begin
        sel_op_d   = bus.op[2*i +: 2];
        sel_mask_d = bus.mask[WIDTH*i +: WIDTH];
      end else begin
        sel_op_d   = sel_op_d;
        sel_mask_d = sel_mask_d;
      end
    end
  end

  // Expand the latched command into bank J/K vectors, bit by bit.
  always_comb begin
    j_d = {WIDTH{1'b0}};
    k_d = {WIDTH{1'b0}};
    for (int b = 0; b < WIDTH; b++) begin
      {j_d[b], k_d[b]} = jk_decode(op_q, mask_q[b]);
    end
  end

  // Pointer moves just past the served requester, wrapping at NREQ.
  always_comb begin
    if (idx_q == IDW'(NREQ - 1)) begin
      ptr_next_d = {IDW{1'b0}};
    end else begin
      ptr_next_d = idx_q + IDW'(1);
    end
  end

  // Sequencer FSM; every output (grant, id, busy, bank controls) is a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= {IDW{1'b0}};
      idx_q    <= {IDW{1'b0}};
      op_q     <= OP_HOLD;
      mask_q   <= {WIDTH{1'b0}};
      en_q     <= 1'b0;
      j_q      <= {WIDTH{1'b0}};
      k_q      <= {WIDTH{1'b0}};
      gnt_q    <= {NREQ{1'b0}};
      gnt_id_q <= {IDW{1'b0}};
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          gnt_q <= {NREQ{1'b0}};
          en_q  <= 1'b0;
          if (sel_found_d) begin
            op_q    <= sel_op_d;
            mask_q  <= sel_mask_d;
            idx_q   <= sel_idx_d;
            state_q <= ST_APPLY;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_APPLY: begin
          // Only the latched copy drives the bank from here on.
          en_q    <= 1'b1;
          j_q     <= j_d;
          k_q     <= k_d;
          gnt_q   <= {NREQ{1'b0}};
          state_q <= ST_ACK;
          busy_q  <= 1'b1;
        end
        ST_ACK: begin
          // Bank captures on this edge, so q is current while gnt is high.
          en_q     <= 1'b0;
          j_q      <= {WIDTH{1'b0}};
          k_q      <= {WIDTH{1'b0}};
          gnt_q    <= {{(NREQ-1){1'b0}}, 1'b1} << idx_q;
          gnt_id_q <= idx_q;
          ptr_q    <= ptr_next_d;
          state_q  <= ST_IDLE;
          busy_q   <= 1'b0;
        end
        default: begin
          en_q    <= 1'b0;
          gnt_q   <= {NREQ{1'b0}};
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  jk_ff_bank #(
    .WIDTH (WIDTH)
  ) u_bank (
    .clk (clk),
    .rst (rst),
    .en  (en_q),
    .j   (j_q),
    .k   (k_q),
    .q   (bank_q)
  );

  assign bus.gnt    = gnt_q;
  assign bus.gnt_id = gnt_id_q;
  assign bus.busy   = busy_q;
  assign bus.q      = bank_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter (WIDTH=8, NREQ=4): a vector table of
// single transactions plus hand-written multi-cycle sequences.
module tb_jk_bank_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  jk_bank_arbiter_if #(.WIDTH(8), .NREQ(4)) bus ();

  jk_bank_arbiter #(.WIDTH(8), .NREQ(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  req;
    logic [7:0]  op;
    logic [31:0] mask;
    logic [7:0]  exp_q;
    logic [3:0]  exp_gnt;
    logic [1:0]  exp_id;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Wait (bounded) for a nonzero gnt, sampling on falling edges.
  task automatic wait_gnt(input int start_n, output int n, output logic [3:0] g);
    n = start_n;
    g = bus.gnt;
    while (g == 4'b0000 && n < 12) begin
      @(negedge clk);
      n++;
      g = bus.gnt;
    end
    if (g == 4'b0000) begin
      check("gnt_timeout", 64'(n), 64'(3));
    end
  endtask

  initial begin
    int          n;
    logic [3:0]  g;
    logic [3:0]  seen;

    n_checks = 0;
    n_fail   = 0;

    //             req      op      mask            q      gnt      id
    vecs[0] = '{4'b0001, 8'hFE, 32'hFFFF_FFF0, 8'hF0, 4'b0001, 2'd0};
    vecs[1] = '{4'b0010, 8'h0C, 32'hAAAA_FFAA, 8'h0F, 4'b0010, 2'd1};
    vecs[2] = '{4'b0010, 8'h0C, 32'hAAAA_FFAA, 8'hF0, 4'b0010, 2'd1};
    vecs[3] = '{4'b0100, 8'hDF, 32'hFF30_FFFF, 8'hC0, 4'b0100, 2'd2};
    vecs[4] = '{4'b1000, 8'h2A, 32'hFF00_0000, 8'hC0, 4'b1000, 2'd3};
    vecs[5] = '{4'b0001, 8'h02, 32'hFFFF_FF00, 8'hC0, 4'b0001, 2'd0};
    vecs[6] = '{4'b0100, 8'h30, 32'h0080_0000, 8'h40, 4'b0100, 2'd2};

    bus.req  = 4'b0000;
    bus.op   = 8'h00;
    bus.mask = 32'h0000_0000;
    rst      = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_q",      64'(bus.q),      64'(8'h00));
    check("reset_gnt",    64'(bus.gnt),    64'(4'b0000));
    check("reset_gnt_id", 64'(bus.gnt_id), 64'(2'd0));
    check("reset_busy",   64'(bus.busy),   64'(1'b0));

    // Table of single transactions.
    for (int i = 0; i < 7; i++) begin
      bus.req  = vecs[i].req;
      bus.op   = vecs[i].op;
      bus.mask = vecs[i].mask;
      @(negedge clk);
      check("vec_busy", 64'(bus.busy), 64'(1'b1));
      wait_gnt(1, n, g);
      check("vec_latency", 64'(n), 64'(3));
      check("vec_gnt",     64'(g), 64'(vecs[i].exp_gnt));
      check("vec_q",       64'(bus.q), 64'(vecs[i].exp_q));
      check("vec_gnt_id",  64'(bus.gnt_id), 64'(vecs[i].exp_id));
      bus.req = 4'b0000;
      @(negedge clk);
      check("vec_gnt_pulse", 64'(bus.gnt),  64'(4'b0000));
      check("vec_idle_busy", 64'(bus.busy), 64'(1'b0));
    end

    // Pointer wrap: ptr is 3 after serving requester 2.
    bus.req  = 4'b1001;
    bus.op   = 8'h00;
    bus.mask = 32'hFFFF_FFFF;
    wait_gnt(0, n, g);
    check("wrap_first_lat", 64'(n), 64'(3));
    check("wrap_first_gnt", 64'(g), 64'(4'b1000));
    check("wrap_first_id",  64'(bus.gnt_id), 64'(2'd3));
    bus.req = 4'b0001;
    @(negedge clk);
    wait_gnt(1, n, g);
    check("wrap_second_lat", 64'(n), 64'(3));
    check("wrap_second_gnt", 64'(g), 64'(4'b0001));
    check("wrap_q_hold",     64'(bus.q), 64'(8'h40));
    bus.req = 4'b0000;
    @(negedge clk);

    // Mid-flight change: requester 2 latched with set/01, then rewritten.
    bus.req  = 4'b0100;
    bus.op   = 8'h20;
    bus.mask = 32'h0001_0000;
    @(negedge clk);
    bus.op   = 8'h10;
    bus.mask = 32'h00FF_0000;
    wait_gnt(1, n, g);
    check("mid_lat", 64'(n), 64'(3));
    check("mid_gnt", 64'(g), 64'(4'b0100));
    check("mid_q",   64'(bus.q), 64'(8'h41));
    bus.req = 4'b0000;
    @(negedge clk);

    // Reset while in APPLY: command dropped, everything back to reset state.
    bus.req  = 4'b0001;
    bus.op   = 8'h02;
    bus.mask = 32'h0000_00FF;
    @(negedge clk);
    rst     = 1'b1;
    bus.req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    check("rst_apply_q",      64'(bus.q),      64'(8'h00));
    check("rst_apply_busy",   64'(bus.busy),   64'(1'b0));
    check("rst_apply_gnt",    64'(bus.gnt),    64'(4'b0000));
    check("rst_apply_gnt_id", 64'(bus.gnt_id), 64'(2'd0));
    seen = 4'b0000;
    repeat (4) begin
      @(negedge clk);
      seen = seen | bus.gnt;
    end
    check("rst_apply_no_gnt", 64'(seen), 64'(4'b0000));

    // Reset while in ACK: the bank write on that edge must lose to reset.
    bus.req = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    rst     = 1'b1;
    bus.req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    check("rst_ack_q",    64'(bus.q),    64'(8'h00));
    check("rst_ack_gnt",  64'(bus.gnt),  64'(4'b0000));
    check("rst_ack_busy", 64'(bus.busy), 64'(1'b0));
    seen = 4'b0000;
    repeat (4) begin
      @(negedge clk);
      seen = seen | bus.gnt;
    end
    check("rst_ack_no_gnt", 64'(seen), 64'(4'b0000));

    // Fairness from ptr=0: all requesting hold, order 0,1,2,3,0 every 3 cycles.
    bus.req  = 4'b1111;
    bus.op   = 8'h00;
    bus.mask = 32'hFFFF_FFFF;
    for (int k = 0; k < 5; k++) begin
      if (k == 0) begin
        wait_gnt(0, n, g);
      end else begin
        @(negedge clk);
        wait_gnt(1, n, g);
      end
      check("fair_lat", 64'(n), 64'(3));
      check("fair_gnt", 64'(g), 64'(4'b0001 << (k % 4)));
      check("fair_q",   64'(bus.q), 64'(8'h00));
    end
    bus.req = 4'b0000;
    @(negedge clk);
    check("fair_gnt_pulse", 64'(bus.gnt), 64'(4'b0000));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
